// File: rtl/decode_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile_stage
// Description : 32x32 register file with write-through read bypass, load-use
//               hazard stall generation and the D/E pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic        validD,
    input  logic        regWriteDS,
    input  logic [4:0]  write_regDS,
    input  logic [31:0] data_out,
    input  logic        memReadE,
    input  logic        flushD,
    output logic        stallF,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE,
    output logic [31:0] pcE,
    output logic [31:0] instrE,
    output logic        validE
);

    logic [31:0] regs [0:31];

    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic        wb_write;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        load_use;

    assign rs1_d    = instrD[19:15];
    assign rs2_d    = instrD[24:20];
    assign rd_d     = instrD[11:7];
    assign wb_write = regWriteDS && (write_regDS != 5'd0);

    // Writeback data lands a cycle late, so the same-cycle write must bypass
    // the array to reach the instruction being decoded.
    always_comb begin
        rs1_val = regs[rs1_d];
        rs2_val = regs[rs2_d];
        if (wb_write && (write_regDS == rs1_d)) rs1_val = data_out;
        if (wb_write && (write_regDS == rs2_d)) rs2_val = data_out;
        if (rs1_d == 5'd0) rs1_val = 32'd0;
        if (rs2_d == 5'd0) rs2_val = 32'd0;
    end

    // Both source fields are compared regardless of opcode.
    assign load_use = validD && validE && memReadE && (rdE != 5'd0) &&
                      ((rdE == rs1_d) || (rdE == rs2_d));
    assign stallF   = load_use && !flushD;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_write) begin
            regs[write_regDS] <= data_out;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flushD || stallF) begin
            validE <= 1'b0;
            instrE <= NOP_INSTR;
            pcE    <= 32'd0;
            rd1E   <= 32'd0;
            rd2E   <= 32'd0;
            rs1E   <= 5'd0;
            rs2E   <= 5'd0;
            rdE    <= 5'd0;
        end else begin
            validE <= validD;
            instrE <= instrD;
            pcE    <= pcD;
            rd1E   <= rs1_val;
            rd2E   <= rs2_val;
            rs1E   <= rs1_d;
            rs2E   <= rs2_d;
            rdE    <= rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_regfile_stage
// Description : Directed self-checking bench for decode_regfile_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_regfile_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
    logic        regWriteDS;
    logic [4:0]  write_regDS;
    logic [31:0] data_out;
    logic        memReadE;
    logic        flushD;
    logic        stallF;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic [31:0] pcE;
    logic [31:0] instrE;
    logic        validE;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    decode_regfile_stage #(.NOP_INSTR(NOP)) dut (
        .clock       (clock),
        .reset       (reset),
        .instrD      (instrD),
        .pcD         (pcD),
        .validD      (validD),
        .regWriteDS  (regWriteDS),
        .write_regDS (write_regDS),
        .data_out    (data_out),
        .memReadE    (memReadE),
        .flushD      (flushD),
        .stallF      (stallF),
        .rd1E        (rd1E),
        .rd2E        (rd2E),
        .rs1E        (rs1E),
        .rs2E        (rs2E),
        .rdE         (rdE),
        .pcE         (pcE),
        .instrE      (instrE),
        .validE      (validE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " validE"}, {31'd0, validE}, 32'd0);
        check({tag, " instrE"}, instrE, NOP);
        check({tag, " pcE"},    pcE, 32'd0);
        check({tag, " rd1E"},   rd1E, 32'd0);
        check({tag, " rd2E"},   rd2E, 32'd0);
        check({tag, " rs1E"},   {27'd0, rs1E}, 32'd0);
        check({tag, " rs2E"},   {27'd0, rs2E}, 32'd0);
        check({tag, " rdE"},    {27'd0, rdE}, 32'd0);
        check({tag, " stallF"}, {31'd0, stallF}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; instrD = NOP; pcD = 32'd0; validD = 1'b0;
        regWriteDS = 1'b0; write_regDS = 5'd0; data_out = 32'd0;
        memReadE = 1'b0; flushD = 1'b0;
        tick();
        tick();
        check_reset_values("reset");

        // Write x5 while a non-valid slot is presented
        reset = 1'b1;
        regWriteDS = 1'b1; write_regDS = 5'd5; data_out = 32'hDEADBEEF;
        validD = 1'b0; instrD = NOP; pcD = 32'h44;
        tick();
        check("bubble validE", {31'd0, validE}, 32'd0);
        check("bubble pcE", pcE, 32'h44);

        // add x1,x5,x0
        regWriteDS = 1'b0;
        validD = 1'b1; instrD = 32'h000280B3; pcD = 32'h100;
        tick();
        check("basic rd1E", rd1E, 32'hDEADBEEF);
        check("basic rd2E", rd2E, 32'd0);
        check("basic rs1E", {27'd0, rs1E}, 32'd5);
        check("basic rdE", {27'd0, rdE}, 32'd1);
        check("basic validE", {31'd0, validE}, 32'd1);
        check("basic pcE", pcE, 32'h100);
        check("basic instrE", instrE, 32'h000280B3);

        // add x2,x5,x7 with concurrent write x7=0x1234
        regWriteDS = 1'b1; write_regDS = 5'd7; data_out = 32'h1234;
        instrD = 32'h00728133; pcD = 32'h104;
        tick();
        check("bypass rd2E", rd2E, 32'h1234);
        check("bypass rd1E", rd1E, 32'hDEADBEEF);
        check("bypass rs2E", {27'd0, rs2E}, 32'd7);

        // add x3,x7,x0 reads x7 from the array
        regWriteDS = 1'b0;
        instrD = 32'h000381B3; pcD = 32'h108;
        tick();
        check("array x7 rd1E", rd1E, 32'h1234);

        // add x1,x0,x0 with concurrent write to x0
        regWriteDS = 1'b1; write_regDS = 5'd0; data_out = 32'hFFFFFFFF;
        instrD = 32'h000000B3; pcD = 32'h10C;
        tick();
        check("x0 bypass rd1E", rd1E, 32'd0);
        check("x0 bypass rd2E", rd2E, 32'd0);
        regWriteDS = 1'b0;
        tick();
        check("x0 array rd1E", rd1E, 32'd0);
        check("x0 array rd2E", rd2E, 32'd0);

        // lw x3,0(x2) into E, then add x4,x3,x2 in decode
        instrD = 32'h00012183; pcD = 32'h110;
        tick();
        check("lw rdE", {27'd0, rdE}, 32'd3);
        memReadE = 1'b1;
        instrD = 32'h00218233; pcD = 32'h114;
        #1;
        check("load-use stallF", {31'd0, stallF}, 32'd1);
        tick();
        check("stall bubble validE", {31'd0, validE}, 32'd0);
        check("stall bubble instrE", instrE, NOP);
        check("stall bubble rdE", {27'd0, rdE}, 32'd0);
        memReadE = 1'b0;
        #1;
        check("after bubble stallF", {31'd0, stallF}, 32'd0);
        tick();
        check("replay validE", {31'd0, validE}, 32'd1);
        check("replay rs1E", {27'd0, rs1E}, 32'd3);
        check("replay rdE", {27'd0, rdE}, 32'd4);
        check("replay instrE", instrE, 32'h00218233);

        // lw x0,0(x2) then add x4,x0,x2: rdE=0 never stalls
        instrD = 32'h00012003; pcD = 32'h118;
        tick();
        memReadE = 1'b1;
        instrD = 32'h00200233; pcD = 32'h11C;
        #1;
        check("rdE zero stallF", {31'd0, stallF}, 32'd0);
        memReadE = 1'b0;

        // lw x3 then add x4,x2,x3 (rs2 match), flush overrides the stall
        instrD = 32'h00012183; pcD = 32'h120;
        tick();
        memReadE = 1'b1;
        instrD = 32'h00310233; pcD = 32'h124;
        #1;
        check("rs2 load-use stallF", {31'd0, stallF}, 32'd1);
        flushD = 1'b1;
        #1;
        check("flush stallF", {31'd0, stallF}, 32'd0);
        tick();
        check("flush validE", {31'd0, validE}, 32'd0);
        check("flush instrE", instrE, NOP);
        flushD = 1'b0; memReadE = 1'b0;

        // Fill x1..x31 with 0x1000+i
        validD = 1'b0; instrD = NOP;
        regWriteDS = 1'b1;
        for (int i = 1; i < 32; i++) begin
            write_regDS = 5'(i); data_out = 32'h1000 + 32'(i);
            tick();
        end
        regWriteDS = 1'b0;
        validD = 1'b1; instrD = (32'd31 << 20) | (32'd9 << 15) | 32'h33; pcD = 32'h200;
        tick();
        check("fill x9", rd1E, 32'h1009);
        check("fill x31", rd2E, 32'h101F);

        // Reset with a concurrent write to x9 while a valid instruction decodes
        reset = 1'b0;
        regWriteDS = 1'b1; write_regDS = 5'd9; data_out = 32'hAAAA;
        instrD = 32'h000280B3; pcD = 32'h204;
        tick();
        check_reset_values("midreset");
        reset = 1'b1; regWriteDS = 1'b0;

        for (int i = 1; i < 32; i += 2) begin
            instrD = (32'((i + 1) % 32) << 20) | (32'(i) << 15) | 32'h33;
            tick();
            check($sformatf("cleared x%0d", i), rd1E, 32'd0);
            check($sformatf("cleared x%0d", (i + 1) % 32), rd2E, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_regfile_stage.md
# decode_regfile_stage

Decode-side endpoint of the writeback interface: holds the 32×32 integer register file written by the writeback stage and reads two source operands for the instruction in decode. It detects load-use hazards and produces the fetch stall. It registers operands and instruction fields into the D/E pipeline register that feeds the execute stage.

## Interface
- `NOP_INSTR`, default 32'h0000_0013: instruction word inserted into E on a bubble.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `instrD` in 32: instruction in decode, from the F/D register.
- `pcD` in 32: PC of `instrD`.
- `validD` in 1: `instrD` is a real instruction; 0 means bubble.
- `regWriteDS` in 1: write enable from the writeback stage.
- `write_regDS` in 5: destination register from writeback.
- `data_out` in 32: write data from writeback.
- `memReadE` in 1: the instruction currently in E is a load. Driven by execute decode of `instrE`.
- `flushD` in 1: taken branch/jump; kill the instruction in decode.
- `stallF` out 1: hold PC and the F/D register this cycle.
- `rd1E`, `rd2E` out 32: registered operand values.
- `rs1E`, `rs2E`, `rdE` out 5: registered source and destination indices, for forwarding.
- `pcE`, `instrE` out 32: registered PC and instruction.
- `validE` out 1: E holds a real instruction.

## Operation
- Field extraction: rs1D = `instrD[19:15]`, rs2D = `instrD[24:20]`, rdD = `instrD[11:7]`.
- Register file:
  - 32 entries × 32 bits.
  - Write on the rising edge when `regWriteDS`=1 and `write_regDS`≠0. Writes to x0 are discarded.
  - x0 always reads 0.
- Read path is combinational with write-through bypass. If `regWriteDS`=1, `write_regDS`≠0 and `write_regDS`==rsXD, the read returns `data_out` instead of the array entry. This is required because writeback delivers its data one cycle after W.
- Hazard logic:
  - `stallF` = `validD` & `validE` & `memReadE` & (`rdE`≠0) & (`rdE`==rs1D | `rdE`==rs2D).
  - Both sources are compared for every opcode; this is deliberately conservative.
  - `stallF` is combinational and is forced to 0 while `flushD`=1.
- D/E register update, in priority order:
  1. `reset`=0: all E outputs = 0, `instrE`=`NOP_INSTR`, `validE`=0. All 32 register file entries are cleared to 0. A concurrent write is ignored.
  2. `flushD`=1: bubble — `validE`=0, `instrE`=`NOP_INSTR`, all other E outputs = 0.
  3. `stallF`=1: bubble into E, same values as flush. F/D is held externally, so the same `instrD` is re-decoded next cycle.
  4. Otherwise: capture `validD`, `pcD`, `instrD`, rs1D, rs2D, rdD, and both bypassed read values.
- When `validD`=0 the captured `validE`=0, and `instrE`, `pcE` and the indices are still captured as presented.
- A write to the register file is never blocked by stall or flush.

## Timing
- Write to read: a value written in cycle N is visible to decode in cycle N (via bypass) and in the array from N+1.
- Decode to E: one-cycle latency. E outputs reflect cycle-N decode after edge N.
- Load-use: exactly one bubble per dependent load. In the cycle after the bubble `validE`=0, so `stallF` deasserts.
- `flushD` and `stallF` in the same cycle: flush wins and `stallF`=0, so fetch is free to redirect.
- Reset mid-stall: after the reset edge `validE`=0 and `stallF`=0.
- Reset values: every E output is 0 except `instrE`=`NOP_INSTR`. `stallF` is 0 once `validE`=0.

## Test plan
- Basic write/read:
  - Stimulus: write x5=0xDEADBEEF.
  - Next cycle decode `add x1,x5,x0` (0x000280B3).
  - Required: `rd1E`=0xDEADBEEF, `rd2E`=0, `rs1E`=5, `rdE`=1, `validE`=1.
- Same-cycle bypass:
  - Stimulus: `regWriteDS`=1, `write_regDS`=7, `data_out`=0x1234 while decoding an instruction with rs2=7.
  - Required: `rd2E`=0x1234 on the following edge.
- x0 protection:
  - Stimulus: write 0xFFFFFFFF to x0, then read x0 on both ports, including the same-cycle bypass case.
  - Required: `rd1E`=`rd2E`=0.
- Load-use stall:
  - Stimulus: E holds `lw x3` (`memReadE`=1, `rdE`=3, `validE`=1); decode presents `add x4,x3,x2`.
  - Required: `stallF`=1 for one cycle. Next edge: `validE`=0, `instrE`=0x00000013. The edge after that captures the add with `rs1E`=3.
  - Same stimulus with `rdE`=0: `stallF`=0.
- Flush priority:
  - Stimulus: the load-use condition above plus `flushD`=1.
  - Required: `stallF`=0; next edge `validE`=0.
- Reset mid-operation:
  - Stimulus: fill x1..x31 with nonzero values, assert `reset`=0 for one edge concurrently with a write to x9.
  - Required: all E outputs at their reset values; subsequent reads of x1..x31 (including x9) return 0.
